// File: rtl/mandel_iter_engine_pkg.sv
// Shared definitions for the Mandelbrot/Julia escape-time engine.
// Optional Julia mode is selected with MANDEL_JULIA_MODE_EN.
package mandel_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SQUARE = 3'd1,
    S_CHECK  = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  // Wide enough for any practical 2*WORD_LENGTH+1 magnitude; callers cast down.
  localparam int THRESH_MAX_W = 130;

  // Escape threshold 4.0 in a Q.frac format: 4 << frac.
  function automatic logic [THRESH_MAX_W-1:0] esc_thresh(input int frac);
    return {{(THRESH_MAX_W-3){1'b0}}, 3'd4} << frac;
  endfunction

endpackage

// File: rtl/mandel_iter_engine_if.sv
// Pixel request / result handshake bundle for mandel_iter_engine.
// Julia-mode sideband signals exist only with MANDEL_JULIA_MODE_EN.
interface mandel_iter_engine_if #(
  parameter int WORD_LENGTH = 32,
  parameter int ITER_W      = 10,
  parameter int TAG_W       = 8
);
  logic                          in_valid;
  logic                          in_ready;
  logic signed [WORD_LENGTH-1:0] in_re;
  logic signed [WORD_LENGTH-1:0] in_im;
  logic [TAG_W-1:0]              in_tag;
  logic [ITER_W-1:0]             max_iter;
  logic                          out_valid;
  logic                          out_ready;
  logic [ITER_W-1:0]             out_depth;
  logic                          out_escaped;
  logic [TAG_W-1:0]              out_tag;
`ifdef MANDEL_JULIA_MODE_EN
  logic                          julia;
  logic signed [WORD_LENGTH-1:0] jc_re;
  logic signed [WORD_LENGTH-1:0] jc_im;

  modport master (output in_valid, in_re, in_im, in_tag, max_iter, out_ready,
                         julia, jc_re, jc_im,
                  input  in_ready, out_valid, out_depth, out_escaped, out_tag);
  modport slave  (input  in_valid, in_re, in_im, in_tag, max_iter, out_ready,
                         julia, jc_re, jc_im,
                  output in_ready, out_valid, out_depth, out_escaped, out_tag);
`else
  modport master (output in_valid, in_re, in_im, in_tag, max_iter, out_ready,
                  input  in_ready, out_valid, out_depth, out_escaped, out_tag);
  modport slave  (input  in_valid, in_re, in_im, in_tag, max_iter, out_ready,
                  output in_ready, out_valid, out_depth, out_escaped, out_tag);
`endif
endinterface

// File: rtl/mandel_iter_engine_cplx_sq.sv
// Registered complex squarer: re^2, im^2 (>>> FRAC) and 2*re*im (>>> FRAC-1).
// Results are full 2*WORD_LENGTH wide so the caller can form |z|^2 without wrap.
module mandel_cplx_sq #(
  parameter int WORD_LENGTH = 32,
  parameter int FRAC        = 28
) (
  input  logic                            sysclk,
  input  logic                            reset,
  input  logic                            i_en,
  input  logic signed [WORD_LENGTH-1:0]   i_re,
  input  logic signed [WORD_LENGTH-1:0]   i_im,
  output logic signed [2*WORD_LENGTH-1:0] o_re2,
  output logic signed [2*WORD_LENGTH-1:0] o_im2,
  output logic signed [2*WORD_LENGTH-1:0] o_2reim
);
  localparam int W2 = 2 * WORD_LENGTH;

  logic signed [W2-1:0] w_rr, w_ii, w_ri;
  logic signed [W2-1:0] r_re2, r_im2, r_2reim;

  assign w_rr = W2'(i_re) * W2'(i_re);
  assign w_ii = W2'(i_im) * W2'(i_im);
  assign w_ri = W2'(i_re) * W2'(i_im);

  // Capture the scaled products while the engine sits in its square stage.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_re2   <= '0;
      r_im2   <= '0;
      r_2reim <= '0;
    end else if (i_en) begin
      r_re2   <= w_rr >>> FRAC;
      r_im2   <= w_ii >>> FRAC;
      r_2reim <= w_ri >>> (FRAC - 1);
    end
  end

  assign o_re2   = r_re2;
  assign o_im2   = r_im2;
  assign o_2reim = r_2reim;
endmodule

// File: rtl/mandel_iter_engine.sv
// Escape-time engine for one pixel: z <- z^2 + c in signed Q(W-FRAC).FRAC.
// Define MANDEL_JULIA_MODE_EN to add the julia/jc_re/jc_im inputs.
module mandel_iter_engine
  import mandel_pkg::*;
#(
  parameter int WORD_LENGTH = 32,
  parameter int FRAC        = 28,
  parameter int ITER_W      = 10,
  parameter int TAG_W       = 8
) (
  input logic                  sysclk,
  input logic                  reset,
  mandel_iter_engine_if.slave  bus
);
  localparam int W2 = 2 * WORD_LENGTH;
  localparam logic signed [W2:0] THRESH = (W2+1)'(esc_thresh(FRAC));

  typedef struct packed {
    logic signed [WORD_LENGTH-1:0] re;
    logic signed [WORD_LENGTH-1:0] im;
  } cplx_t;

  state_e             r_state;
  cplx_t              r_z, r_c;
  logic [ITER_W-1:0]  r_depth, r_max;
  logic [TAG_W-1:0]   r_tag;
  logic               r_esc;

  logic signed [W2-1:0] w_re2, w_im2, w_2reim;
  logic signed [W2:0]   w_mag;
  logic                 w_escape;
  cplx_t                w_z0, w_c0, w_znext;

  mandel_cplx_sq #(.WORD_LENGTH(WORD_LENGTH), .FRAC(FRAC)) u_sq (
    .sysclk  (sysclk),
    .reset   (reset),
    .i_en    (r_state == S_SQUARE),
    .i_re    (r_z.re),
    .i_im    (r_z.im),
    .o_re2   (w_re2),
    .o_im2   (w_im2),
    .o_2reim (w_2reim)
  );

  // One extra bit so re^2 + im^2 never wraps.
  assign w_mag    = {w_re2[W2-1], w_re2} + {w_im2[W2-1], w_im2};
  assign w_escape = w_mag > THRESH;

  // The escape test runs first, so z stays small enough for plain truncation.
  assign w_znext.re = r_c.re + WORD_LENGTH'(w_re2 - w_im2);
  assign w_znext.im = r_c.im + WORD_LENGTH'(w_2reim);

`ifdef MANDEL_JULIA_MODE_EN
  // Julia: pixel is z0, constant comes from jc; otherwise Mandelbrot.
  always_comb begin
    w_z0 = '0;
    w_c0 = {bus.in_re, bus.in_im};
    if (bus.julia) begin
      w_z0 = {bus.in_re, bus.in_im};
      w_c0 = {bus.jc_re, bus.jc_im};
    end
  end
`else
  assign w_z0 = '0;
  assign w_c0 = {bus.in_re, bus.in_im};
`endif

  // Main sequencer: accept, square, check, update, hold result.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_z     <= '0;
      r_c     <= '0;
      r_depth <= '0;
      r_max   <= '0;
      r_tag   <= '0;
      r_esc   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.in_valid) begin
          r_z     <= w_z0;
          r_c     <= w_c0;
          r_tag   <= bus.in_tag;
          r_max   <= bus.max_iter;
          r_depth <= '0;
          r_esc   <= 1'b0;
          r_state <= S_SQUARE;
        end
        S_SQUARE: r_state <= S_CHECK;
        S_CHECK: begin
          if (w_escape) begin
            r_esc   <= 1'b1;
            r_state <= S_DONE;
          end else if (r_depth == r_max) begin
            r_esc   <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          r_z     <= w_znext;
          r_depth <= r_depth + ITER_W'(1);
          r_state <= S_SQUARE;
        end
        S_DONE:  if (bus.out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == S_IDLE);
  assign bus.out_valid   = (r_state == S_DONE);
  assign bus.out_depth   = r_depth;
  assign bus.out_escaped = r_esc;
  assign bus.out_tag     = r_tag;
endmodule

// File: tb/tb_mandel_iter_engine.sv
// Bench for mandel_iter_engine: directed corner cases plus randomized pixels,
// every output cycle compared against an escape-time model kept in the bench.
module tb_mandel_iter_engine;
  localparam int WL = 32, FR = 28, IW = 10, TW = 8;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  always #5 sysclk = ~sysclk;

  mandel_iter_engine_if #(.WORD_LENGTH(WL), .ITER_W(IW), .TAG_W(TW)) bus();

  mandel_iter_engine #(.WORD_LENGTH(WL), .FRAC(FR), .ITER_W(IW), .TAG_W(TW)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  typedef struct {
    int due;
    int acc;
    int depth;
    bit esc;
    int tag;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;
  int   last_depth, last_lat, last_acc, last_pop, last_tag;
  bit   last_esc;
  bit   prev_ov;
  int   rdy_mode = 1;  // 0 low, 1 high, 2 random

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Escape-time reference: iterate the complex recurrence in 64-bit integers.
  function automatic void model(input int zr0, input int zi0, input int cr, input int ci,
                                input int mi, output int d, output bit esc);
    longint zr, zi, rr, ii, ri;
    zr = zr0; zi = zi0; d = 0; esc = 0;
    for (int k = 0; k <= 1100; k++) begin
      rr = (zr * zr) >>> FR;
      ii = (zi * zi) >>> FR;
      ri = (zr * zi) >>> (FR - 1);
      if (rr + ii > (longint'(4) <<< FR)) begin esc = 1; return; end
      if (d == mi) return;
      zr = longint'(int'(rr - ii + cr));
      zi = longint'(int'(ri + ci));
      d++;
    end
  endfunction

  // Per-cycle compare of handshakes and result fields against the model queue.
  initial begin
    exp_t e;
    bit   exp_ov;
    int   md, zr0, zi0, cr, ci;
    bit   me;
    forever begin
      @(negedge sysclk);
      if (reset) begin
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        q.delete();
        prev_ov = 0;
      end else begin
        exp_ov = (q.size() != 0) && (cyc >= q[0].due);
        chk("out_valid", bus.out_valid, exp_ov);
        chk("in_ready", bus.in_ready, q.size() == 0);
        if (bus.out_valid && q.size() != 0) begin
          chk("out_depth", bus.out_depth, q[0].depth);
          chk("out_escaped", bus.out_escaped, q[0].esc);
          chk("out_tag", bus.out_tag, q[0].tag);
          if (!prev_ov) begin
            last_depth = bus.out_depth;
            last_esc   = bus.out_escaped;
            last_tag   = bus.out_tag;
            last_lat   = cyc - q[0].acc;
          end
          if (bus.out_ready) begin
            last_pop = cyc;
            void'(q.pop_front());
          end
        end
        prev_ov = bus.out_valid;
        if (bus.in_valid && bus.in_ready) begin
          zr0 = 0; zi0 = 0; cr = bus.in_re; ci = bus.in_im;
`ifdef MANDEL_JULIA_MODE_EN
          if (bus.julia) begin
            zr0 = bus.in_re; zi0 = bus.in_im; cr = bus.jc_re; ci = bus.jc_im;
          end
`endif
          model(zr0, zi0, cr, ci, int'(bus.max_iter), md, me);
          e.acc = cyc; e.depth = md; e.esc = me; e.tag = int'(bus.in_tag);
          e.due = cyc + 3 + 3 * md;
          q.push_back(e);
          last_acc = cyc;
        end
      end
    end
  end

  // Sole driver of out_ready.
  initial begin
    forever begin
      @(posedge sysclk); #3;
      case (rdy_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: run did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic set_px(input int re, input int im, input int tag, input int mi,
                        input bit jul, input int jre, input int jim);
    bus.in_re = re; bus.in_im = im; bus.in_tag = TW'(tag); bus.max_iter = IW'(mi);
`ifdef MANDEL_JULIA_MODE_EN
    bus.julia = jul; bus.jc_re = jre; bus.jc_im = jim;
`else
    if (jul || jre != 0 || jim != 0) $display("note: julia fields ignored in this build");
`endif
  endtask

  task automatic send(input int re, input int im, input int tag, input int mi,
                      input bit jul = 0, input int jre = 0, input int jim = 0);
    int n;
    @(posedge sysclk); #2;
    set_px(re, im, tag, mi, jul, jre, jim);
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 5000) begin @(posedge sysclk); #2; n++; end
    chk("accept_timeout", bus.in_ready, 1);
    @(posedge sysclk); #2;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 5000) begin @(posedge sysclk); n++; end
    chk("done_timeout", q.size(), 0);
    @(posedge sysclk); #2;
  endtask

  initial begin
    int md, n, rr, ri, rt, rm, jr, ji;
    bit me, jul;
    bus.in_valid = 1'b0;
    set_px(0, 0, 0, 0, 1'b0, 0, 0);
    repeat (3) @(posedge sysclk);
    #2 reset = 1'b0;

    @(negedge sysclk);
    chk("reset_depth", bus.out_depth, 0);
    chk("reset_escaped", bus.out_escaped, 0);
    chk("reset_tag", bus.out_tag, 0);
    chk("reset_in_ready", bus.in_ready, 1);

    // Pin the model on hand-worked trajectories.
    model(0, 0, 32'h1000_0000, 0, 100, md, me);
    chk("model_c1_depth", md, 3); chk("model_c1_esc", me, 1);
    model(0, 0, 32'hE000_0000, 0, 50, md, me);
    chk("model_cm2_depth", md, 50); chk("model_cm2_esc", me, 0);
    model(32'h1800_0000, 0, 0, 0, 100, md, me);
    chk("model_julia_depth", md, 1); chk("model_julia_esc", me, 1);

    // c = 0 never escapes.
    send(0, 0, 8'h11, 20); wait_done();
    chk("c0_depth", last_depth, 20); chk("c0_esc", last_esc, 0);
    chk("c0_tag", last_tag, 8'h11); chk("c0_latency", last_lat, 63);

    // c = 1.0: 0,1,2,5 -> escapes on the third update.
    send(32'h1000_0000, 0, 8'h22, 100); wait_done();
    chk("c1_depth", last_depth, 3); chk("c1_esc", last_esc, 1);
    chk("c1_latency", last_lat, 12);

    // c = -2.0 parks at |z|^2 == 4, which must not count as escape.
    send(32'hE000_0000, 0, 8'h33, 50); wait_done();
    chk("cm2_depth", last_depth, 50); chk("cm2_esc", last_esc, 0);

    // max_iter = 0 finishes at the first check.
    send(int'($urandom_range(0, 32'h7FFF_FFFF)), int'($urandom), 8'hA5, 0); wait_done();
    chk("mi0_depth", last_depth, 0); chk("mi0_esc", last_esc, 0);
    chk("mi0_tag", last_tag, 8'hA5); chk("mi0_latency", last_lat, 3);

    // Backpressure: result held, a waiting request only enters after the handshake.
    rdy_mode = 0;
    send(32'h2000_0000, 0, 8'h5A, 100);
    n = 0;
    while (!bus.out_valid && n < 200) begin @(posedge sysclk); #2; n++; end
    chk("hold_reach_done", bus.out_valid, 1);
    set_px(0, 0, 8'h3C, 0, 1'b0, 0, 0);
    bus.in_valid = 1'b1;
    repeat (10) begin @(posedge sysclk); #2; end
    chk("hold_depth", bus.out_depth, 2); chk("hold_esc", bus.out_escaped, 1);
    chk("hold_tag", bus.out_tag, 8'h5A); chk("hold_in_ready", bus.in_ready, 0);
    chk("hold_out_valid", bus.out_valid, 1);
    rdy_mode = 1;
    n = 0;
    while (!bus.in_ready && n < 20) begin @(posedge sysclk); #2; n++; end
    @(posedge sysclk); #2;
    bus.in_valid = 1'b0;
    chk("hold_accept_gap", last_acc - last_pop, 1);
    wait_done();
    chk("hold2_depth", last_depth, 0); chk("hold2_tag", last_tag, 8'h3C);

    // Reset mid-iteration drops the pixel.
    send(0, 0, 8'h44, 20);
    repeat (6) @(posedge sysclk);
    #2 reset = 1'b1;
    @(negedge sysclk);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_depth", bus.out_depth, 0);
    @(posedge sysclk); #2 reset = 1'b0;
    send(32'h1000_0000, 0, 8'h55, 100); wait_done();
    chk("postrst_depth", last_depth, 3); chk("postrst_esc", last_esc, 1);
    chk("postrst_tag", last_tag, 8'h55);

`ifdef MANDEL_JULIA_MODE_EN
    send(32'h1800_0000, 0, 8'h66, 100, 1'b1, 0, 0); wait_done();
    chk("julia_depth", last_depth, 1); chk("julia_esc", last_esc, 1);
`endif

    // Random pixels with random downstream stalls.
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      rr  = int'($urandom_range(0, 32'd1342177280)) - 671088640;
      ri  = int'($urandom_range(0, 32'd1342177280)) - 671088640;
      rm  = int'($urandom_range(0, 40));
      rt  = int'($urandom_range(0, 255));
      jul = 1'($urandom_range(0, 1));
      jr  = int'($urandom_range(0, 32'd536870912)) - 268435456;
      ji  = int'($urandom_range(0, 32'd536870912)) - 268435456;
`ifndef MANDEL_JULIA_MODE_EN
      jul = 1'b0; jr = 0; ji = 0;
`endif
      send(rr, ri, rt, rm, jul, jr, ji);
      if ($urandom_range(0, 3) == 0) wait_done();
    end
    wait_done();
    rdy_mode = 1;
    repeat (2) @(posedge sysclk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
